md_hilo_ctrl: RTL and testbench
===============================

// Module: md_hilo_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer and HI/LO owner for the 5-stage MIPS pipeline.
//  Accepts mult/multu/div/divu from the EX stage and counts out a fixed latency before writing HI/LO.
//  While it is busy, it stalls any EX instruction that touches HI/LO:
//  - PC, IF/ID and ID/EX are frozen.
//  - A bubble is inserted into the EX/MEM pipeline register.
// PARAMETERS
//  MUL_LAT  5   busy cycles for mult/multu (>=1)
//  DIV_LAT  10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   rising-edge clock, sole clock
//  reset     in   1   synchronous, active-low (0 = reset)
//  start     in   1   EX holds mult/multu/div/divu this cycle
//  md_op     in   2   00 mult, 01 multu, 10 div, 11 divu; valid with start
//  rs_val    in   32  forwarded rs operand (multiplicand / dividend)
//  rt_val    in   32  forwarded rt operand (multiplier / divisor)
//  hilo_use  in   1   EX instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/md op)
//  hilo_wr   in   1   EX holds mthi/mtlo
//  hilo_sel  in   1   1 = HI, 0 = LO, for hilo_wr
//  hilo_wdata in  32  rs value for mthi/mtlo
//  busy      out  1   operation in flight
//  stall     out  1   freeze PC, IF/ID, ID/EX
//  bubble_m  out  1   force EX/MEM inputs to 0 (IR=nop)
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//  - state=IDLE, cnt=0, hi=0, lo=0.
//  - busy=stall=bubble_m=0.
//  - Reset mid-operation aborts the operation; the pending result is discarded.
//  States and counter
//  - States: IDLE, MUL, DIV. busy = (state!=IDLE), registered state.
//  - IDLE & start at edge E: latch the result into pending {ph,pl}; go to MUL or DIV.
//  - cnt <= LAT-1 at edge E, where LAT = MUL_LAT or DIV_LAT.
//  - MUL/DIV: cnt decrements each edge.
//  - At the edge with cnt==0: hi<=ph, lo<=pl, state<=IDLE.
//  - busy is high for exactly LAT cycles after E.
//  - An mfhi/mflo in the cycle after completion reads the new value.
//  Stall
//  - stall = busy & hilo_use; bubble_m = stall. Both combinational from registered state.
//  - start or hilo_wr while busy is not accepted. The instruction is stalled and re-presented.
//  - Stall drops in the first IDLE cycle.
//  - Non-HI/LO instructions never stall; the pipeline runs alongside the unit.
//  Arithmetic
//  - mult: signed 32x32 -> 64; {ph,pl} = product.
//  - multu: unsigned 32x32 -> 64.
//  - div: pl = signed quotient truncated toward zero; ph = remainder with the sign of the dividend.
//  - divu: unsigned quotient and remainder.
//  - Divisor==0: HI/LO unchanged at completion; full DIV_LAT busy time still spent.
//  - 0x80000000 / -1 (div): lo=0x80000000, hi=0.
//  HI/LO writes and ordering
//  - hilo_wr while !busy: the selected register <= hilo_wdata at the edge.
//  - start & hilo_wr in the same cycle: start wins; the write is ignored.
//  - mfhi/mflo while !busy reads hi/lo directly. No internal forwarding is needed.
//  - start is accepted back-to-back on the completion cycle's next IDLE cycle only. No overlap.
// TESTING
//  1. Reset=0 for 2 cycles, then release -> hi=lo=0, busy=stall=bubble_m=0.
//  2. mult rs=0xFFFFFFFF rt=2 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//     multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
//  3. div rs=-7 rt=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     divu rs=7 rt=0 -> hi/lo unchanged, busy for 10 cycles.
//  4. mflo (hilo_use=1) presented 1 cycle after a mult start:
//     - stall=bubble_m=1 for 4 cycles, 0 in the 5th busy cycle? No: 1 for all remaining busy cycles.
//     - 0 in the first IDLE cycle, where lo holds the product.
//  5. Add/lw stream (hilo_use=0) during a div -> stall stays 0 throughout.
//     mthi 0x1234 while busy -> stalled, then applied after completion (hi=0x1234 overrides).
//  6. Reset=0 on the 3rd busy cycle of div 100/3 -> next cycle: busy=0, hi=lo=0.
//     No late write of 33/1 occurs.

Source files
------------

// File: rtl/md_hilo_ctrl.sv
// Multi-cycle mult/div sequencer that owns HI/LO for the 5-stage MIPS pipeline.
// The result is computed when the op is accepted and retired after a fixed latency.
module md_hilo_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_use,
    input  logic        hilo_wr,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        stall,
    output logic        bubble_m,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MUL_CNT0 = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT0 = CW'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   ph_reg, ph_next;
    logic [31:0]   pl_reg, pl_next;
    logic          dz_reg, dz_next;
    logic [31:0]   hi_reg, hi_next;
    logic [31:0]   lo_reg, lo_next;

    logic          signed_op;
    logic [63:0]   mul_a, mul_b, product;
    logic          neg_a, neg_b;
    logic [31:0]   mag_a, mag_b, divisor_safe;
    logic [31:0]   q_mag, r_mag, quot, rem;
    logic [63:0]   result;

    // Division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        signed_op    = ~md_op[0];
        mul_a        = {{32{signed_op & rs_val[31]}}, rs_val};
        mul_b        = {{32{signed_op & rt_val[31]}}, rt_val};
        product      = mul_a * mul_b;
        neg_a        = signed_op & rs_val[31];
        neg_b        = signed_op & rt_val[31];
        mag_a        = neg_a ? (~rs_val + 32'd1) : rs_val;
        mag_b        = neg_b ? (~rt_val + 32'd1) : rt_val;
        divisor_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q_mag        = mag_a / divisor_safe;
        r_mag        = mag_a % divisor_safe;
        quot         = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
        rem          = neg_a ? (~r_mag + 32'd1) : r_mag;
        result       = md_op[1] ? {rem, quot} : product;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ph_next    = ph_reg;
        pl_next    = pl_reg;
        dz_next    = dz_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    ph_next = result[63:32];
                    pl_next = result[31:0];
                    dz_next = md_op[1] & (rt_val == 32'd0);
                    if (md_op[1]) begin
                        state_next = ST_DIV;
                        cnt_next   = DIV_CNT0;
                    end else begin
                        state_next = ST_MUL;
                        cnt_next   = MUL_CNT0;
                    end
                end else if (hilo_wr) begin
                    if (hilo_sel) begin
                        hi_next = hilo_wdata;
                    end else begin
                        lo_next = hilo_wdata;
                    end
                end
            end
            default: begin
                if (cnt_reg == '0) begin
                    // A zero divisor spends the full latency but leaves HI/LO alone.
                    if (!dz_reg) begin
                        hi_next = ph_reg;
                        lo_next = pl_reg;
                    end
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ph_reg    <= '0;
            pl_reg    <= '0;
            dz_reg    <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ph_reg    <= ph_next;
            pl_reg    <= pl_next;
            dz_reg    <= dz_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign stall    = busy & hilo_use;
    assign bubble_m = stall;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Scoreboard bench for md_hilo_ctrl: expected HI/LO pushed at issue, popped by a
// monitor when busy falls; stall/busy timing checked cycle by cycle by the driver.
module tb_md_hilo_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_use;
    logic        hilo_wr;
    logic        hilo_sel;
    logic [31:0] hilo_wdata;
    logic        busy;
    logic        stall;
    logic        bubble_m;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_hilo_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_use(hilo_use),
        .hilo_wr(hilo_wr), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
        .busy(busy), .stall(stall), .bubble_m(bubble_m), .hi(hi), .lo(lo)
    );

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        prev_busy = 1'b0;
    logic [63:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a completed operation is visible as busy falling outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            prev_busy = 1'b0;
            exp_q.delete();
        end else begin
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("scoreboard_hilo", {hi, lo}, mon_e);
                    $display("done: hi=%h lo=%h expected %h", hi, lo, mon_e);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic from the HI/LO rules.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     q64, r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin q64 = sa * sb; return q64; end
            2'b01: begin q64 = ua * ub; return q64; end
            2'b10: begin
                if (b == 32'd0) return {m_hi, m_lo};
                sq = sa / sb;
                sr = sa % sb;
                q64 = sq;
                r64 = sr;
                return {r64[31:0], q64[31:0]};
            end
            default: begin
                if (b == 32'd0) return {m_hi, m_lo};
                q64 = ua / ub;
                r64 = ua % ub;
                return {r64[31:0], q64[31:0]};
            end
        endcase
    endfunction

    task automatic idle_inputs();
        start = 0; md_op = 0; rs_val = 0; rt_val = 0;
        hilo_use = 0; hilo_wr = 0; hilo_sel = 0; hilo_wdata = 0;
    endtask

    // use_mode: 0 = no HI/LO users while busy, 1 = always, 2 = random.
    task automatic do_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int use_mode, input bit wr_too, input bit mthi_during);
        logic [63:0] e;
        int lat;
        lat = op[1] ? DIV_LAT : MUL_LAT;
        e = model(op, a, b);
        start = 1; md_op = op; rs_val = a; rt_val = b; hilo_use = 1;
        hilo_wr = wr_too; hilo_sel = 1'($urandom_range(0, 1)); hilo_wdata = $urandom;
        exp_q.push_back(e);
        $display("issue op=%0d a=%h b=%h expect hi=%h lo=%h", op, a, b, e[63:32], e[31:0]);
        #1;
        check("stall_at_issue", {62'd0, stall, bubble_m}, 64'd0);
        tick();
        start = 0; hilo_wr = 0;
        for (int k = 0; k < lat; k++) begin
            if (mthi_during) begin
                hilo_use = 1; hilo_wr = 1; hilo_sel = 1; hilo_wdata = 32'h1234;
            end else begin
                hilo_use = (use_mode == 1) ? 1'b1 : (use_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            #1;
            check("busy_during_op", {63'd0, busy}, 64'd1);
            check("stall_during_op", {62'd0, stall, bubble_m}, {62'd0, hilo_use, hilo_use});
            tick();
        end
        m_hi = e[63:32];
        m_lo = e[31:0];
        hilo_use = 1;
        #1;
        check("busy_after_lat", {63'd0, busy}, 64'd0);
        check("stall_drop_idle", {62'd0, stall, bubble_m}, 64'd0);
        check("hilo_after_op", {hi, lo}, {m_hi, m_lo});
        if (mthi_during) begin
            tick();
            hilo_wr = 0;
            m_hi = 32'h1234;
            #1;
            check("mthi_replayed", {hi, lo}, {m_hi, m_lo});
        end
        hilo_use = 0;
    endtask

    task automatic do_mt(input logic sel, input logic [31:0] data);
        hilo_wr = 1; hilo_use = 1; hilo_sel = sel; hilo_wdata = data;
        #1;
        check("stall_mt_idle", {62'd0, stall, bubble_m}, 64'd0);
        tick();
        hilo_wr = 0; hilo_use = 0;
        if (sel) m_hi = data; else m_lo = data;
        #1;
        check("hilo_after_mt", {hi, lo}, {m_hi, m_lo});
        $display("mt sel=%0d data=%h -> hi=%h lo=%h", sel, data, hi, lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        idle_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_stall", {62'd0, stall, bubble_m}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        do_md(2'b00, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        check("mult_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_md(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        check("multu_spec", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_md(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        check("div_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_md(2'b11, 32'd7, 32'd0, 0, 0, 0);
        check("divu_zero_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_md(2'b00, 32'd3, 32'd4, 1, 0, 0);
        check("mflo_after_mult", {32'd0, lo}, 64'd12);
        do_md(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        check("div_overflow_spec", {hi, lo}, 64'h0000_0000_8000_0000);
        do_md(2'b10, 32'd1000, 32'd7, 0, 0, 0);
        do_md(2'b11, 32'd50, 32'd9, 0, 0, 1);
        do_mt(1'b0, 32'hCAFE_F00D);

        // Abort: reset lands on the third busy cycle of div 100/3.
        start = 1; md_op = 2'b10; rs_val = 32'd100; rt_val = 32'd3; hilo_use = 1;
        exp_q.push_back(model(2'b10, 32'd100, 32'd3));
        tick();
        start = 0; hilo_use = 0;
        tick();
        tick();
        reset = 0;
        tick();
        reset = 1;
        hilo_use = 1;
        m_hi = 0; m_lo = 0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_stall", {62'd0, stall, bubble_m}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        hilo_use = 0;
        for (int k = 0; k < DIV_LAT + 2; k++) begin
            tick();
            check("no_late_write", {hi, lo}, 64'd0);
            check("no_late_busy", {63'd0, busy}, 64'd0);
        end
        $display("abort: hi=%h lo=%h busy=%0d", hi, lo, busy);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                do_md(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 2,
                      ($urandom_range(0, 3) == 0), 0);
            end else begin
                do_mt(1'($urandom_range(0, 1)), $urandom);
            end
        end

        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
